fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side agent for the synchronous FIFO: pops words via rd_en/empty/d_out
//  and presents them on a valid/ready stream to a downstream consumer.
//  Absorbs the FIFO's one-cycle read latency with a 2-entry output buffer so
//  that back-to-back transfers run at 1 word/cycle. It sits between the
//  FIFO's read port and any consumer, and is the counterpart of the push-side
//  driver.
// PARAMETERS
//  DATA_W   8    data width; must match the FIFO d_in/d_out width
//  CNT_W    16   width of the delivered-word counter
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        synchronous reset, active-low
//  fifo_empty  in   1        FIFO empty flag
//  fifo_d_out  in   DATA_W   FIFO read data, valid the cycle after rd_en
//  fifo_rd_en  out  1        FIFO read enable (pop)
//  m_valid     out  1        stream word available
//  m_ready     in   1        consumer accepts the word
//  m_data      out  DATA_W   stream data (head of the buffer)
//  flush       in   1        drop buffered and in-flight words
//  xfer_cnt    out  CNT_W    count of words accepted by the consumer
//  idle        out  1        occ==0 && !inflight && fifo_empty
// BEHAVIOUR
//  State: buf[0..1] (DATA_W each), rd_ptr/wr_ptr (1 bit), occ (0..2),
//   inflight (1 bit), xfer_cnt.
//  Reset (rst==0 at a clk edge): occ=0, inflight=0, pointers=0, xfer_cnt=0,
//   buf contents=0. As a result m_valid=0, m_data=0, and fifo_rd_en=0 while
//   rst==0. Reset applied mid-transfer discards every word, including any
//   word in flight.
//  pop = m_valid && m_ready. m_valid = (occ!=0). m_data = buf[rd_ptr].
//  fifo_rd_en = rst && !flush && !fifo_empty && (occ + inflight - pop < 2).
//   This is combinational on m_ready, so the block sustains full rate.
//  inflight <= fifo_rd_en (registered each cycle).
//  Capture: when inflight==1 and !flush, buf[wr_ptr] <= fifo_d_out and
//   wr_ptr toggles.
//  occ update:
//   +1 on capture only; -1 on pop only; unchanged when both occur in the
//   same cycle.
//   A capture and a pop in the same cycle both complete; order is preserved.
//  Latency: rd_en in cycle T -> data captured at the edge ending T+1 ->
//   m_valid high in T+2 (empty buffer case).
//  m_data/m_valid hold stable while m_valid && !m_ready. No word is ever
//   dropped or duplicated.
//  Overflow is impossible: the credit check guarantees occ + inflight <= 2.
//  flush (synchronous, one cycle):
//   - next occ=0, pointers=0;
//   - the in-flight word is discarded: no capture happens during the flush
//     cycle, and inflight is cleared;
//   - rd_en=0 during the flush cycle;
//   - xfer_cnt is not incremented during the flush cycle, even if pop.
//  xfer_cnt += 1 on each pop; it wraps modulo 2^CNT_W.
//  fifo_empty and fifo_d_out are ignored while rst==0.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles with the FIFO non-empty -> rd_en=0,
//    m_valid=0, m_data=0, xfer_cnt=0.
//  2 Streaming: push 8'hA1,8'hB2,8'hC3,8'hD4 into the FIFO, m_ready=1 ->
//    words come out in order. First m_valid is 2 cycles after the first
//    rd_en, then 4 consecutive valid cycles; xfer_cnt=4; idle=1 at the end.
//  3 Backpressure: FIFO holds 6 words, m_ready=0 for 10 cycles ->
//    exactly 2 rd_en pulses, occ=2, m_data=first word held stable.
//    Then m_ready=1 -> all 6 words delivered in order, 1 per cycle.
//  4 Simultaneous capture and pop: steady state with occ=1, inflight=1,
//    m_ready=1 -> occ stays 1 and rd_en stays high every cycle until the
//    FIFO is empty.
//  5 Flush with a word in flight: occ=1, inflight=1, pulse flush ->
//    next cycle m_valid=0, the in-flight word is never emitted, and
//    reading resumes with the following FIFO word.
//  6 Reset mid-stream, plus wrap: assert rst=0 during case 2 -> all state
//    cleared, no stray m_valid. Preload xfer_cnt (CNT_W=4) and run 17
//    pops -> xfer_cnt wraps to 1.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side agent for the synchronous FIFO: pops words and presents them on a
// valid/ready stream through a 2-entry buffer that hides the FIFO read latency.
module fifo_stream_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_d_out,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              idle
);

  logic [DATA_W-1:0] buf_q [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              inflight;
  logic [1:0]        occ;
  logic              pop;
  logic              capture;
  logic [2:0]        credit;

  always_comb begin
    m_valid    = (occ != 2'd0);
    m_data     = buf_q[rd_ptr];
    pop        = m_valid && m_ready;
    capture    = inflight && !flush;
    // Slots committed after this cycle; a pop frees one immediately so a
    // steady stream keeps one word buffered and one in flight.
    credit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en = rst && !flush && !fifo_empty && (credit < 3'd2);
    idle       = (occ == 2'd0) && !inflight && fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      inflight <= 1'b0;
      occ      <= '0;
      xfer_cnt <= '0;
    end else if (flush) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      inflight <= 1'b0;
      occ      <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (capture) begin
        buf_q[wr_ptr] <= fifo_d_out;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      case ({capture, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO and stream model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_d_out = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          flush = 1'b0;
  logic [CW-1:0] xfer_cnt;
  logic          idle;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_d_out(fifo_d_out),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .flush(flush), .xfer_cnt(xfer_cnt), .idle(idle)
  );

  int tests = 0;
  int fails = 0;

  // Environment FIFO and behavioural model state
  logic [DW-1:0] fq[$];
  logic [DW-1:0] bq[$];
  logic [DW-1:0] got[$];
  logic [DW-1:0] pend_word = '0;
  logic [DW-1:0] infl_word = '0;
  bit pend_valid = 0, infl = 0, clean = 1, known = 0;
  int cnt = 0;
  bit last_rd, last_valid, last_pop;
  logic [DW-1:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit rdy, input bit f);
    int  exp_rd;
    bit  pop_m;
    @(negedge clk);
    rst        = r;
    m_ready    = rdy;
    flush      = f;
    fifo_d_out = pend_valid ? pend_word : DW'($urandom);
    fifo_empty = (fq.size() == 0);
    #1;
    pop_m  = (bq.size() != 0) && rdy;
    exp_rd = (r && !f && !fifo_empty && (bq.size() + int'(infl) - int'(pop_m) < 2)) ? 1 : 0;
    if (known) begin
      chk("m_valid", m_valid, (bq.size() != 0) ? 1 : 0);
      chk("fifo_rd_en", fifo_rd_en, exp_rd);
      chk("xfer_cnt", xfer_cnt, cnt);
      chk("idle", idle, (bq.size() == 0 && !infl && fifo_empty) ? 1 : 0);
      if (bq.size() != 0) chk("m_data", m_data, bq[0]);
      else if (clean) chk("m_data_zero", m_data, 0);
    end
    last_rd    = fifo_rd_en;
    last_valid = m_valid;
    last_data  = m_data;
    last_pop   = m_valid && rdy && r && !f;
    if (last_pop) got.push_back(m_data);
    pend_valid = 0;
    if (fifo_rd_en && fq.size() != 0) begin
      pend_word  = fq.pop_front();
      pend_valid = 1;
    end
    if (!r) begin
      bq.delete();
      infl  = 0;
      cnt   = 0;
      clean = 1;
      known = 1;
    end else if (f) begin
      bq.delete();
      infl = 0;
    end else begin
      if (pop_m) begin
        void'(bq.pop_front());
        cnt = (cnt + 1) % (1 << CW);
      end
      if (infl) begin
        bq.push_back(infl_word);
        clean = 0;
      end
      infl      = fifo_rd_en;
      infl_word = pend_word;
    end
  endtask

  initial begin
    int t_rd, t_v, t_last, run, pulses, bad, stray;
    logic [DW-1:0] w[8];
    logic [DW-1:0] exp2[4];
    exp2[0] = 8'hA1; exp2[1] = 8'hB2; exp2[2] = 8'hC3; exp2[3] = 8'hD4;

    // Reset with a non-empty FIFO
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    repeat (3) step(0, 0, 0);
    chk("t1_rd_en", last_rd, 0);
    chk("t1_valid", last_valid, 0);
    chk("t1_data", last_data, 0);
    chk("t1_cnt", xfer_cnt, 0);
    fq.delete();
    got.delete();

    // Streaming four words at full rate
    for (int i = 0; i < 4; i++) fq.push_back(exp2[i]);
    t_rd = -1; t_v = -1; t_last = -1; run = 0;
    for (int c = 0; c < 10; c++) begin
      step(1, 1, 0);
      if (last_rd && t_rd < 0) t_rd = c;
      if (last_valid) begin
        if (t_v < 0) t_v = c;
        t_last = c;
        run++;
      end
    end
    chk("t2_latency", t_v - t_rd, 2);
    chk("t2_valid_cycles", run, 4);
    chk("t2_contiguous", t_last - t_v + 1, 4);
    chk("t2_count", got.size(), 4);
    if (got.size() == 4)
      for (int i = 0; i < 4; i++) chk("t2_word", got[i], exp2[i]);
    chk("t2_xfer_cnt", xfer_cnt, 4);
    chk("t2_idle", idle, 1);

    // Backpressure then drain
    got.delete();
    for (int i = 0; i < 6; i++) begin
      w[i] = DW'($urandom);
      fq.push_back(w[i]);
    end
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step(1, 0, 0);
      pulses += int'(last_rd);
    end
    chk("t3_rd_pulses", pulses, 2);
    chk("t3_valid", last_valid, 1);
    chk("t3_hold", last_data, w[0]);
    run = 0;
    for (int c = 0; c < 12; c++) begin
      step(1, 1, 0);
      if (c < 6) run += int'(last_pop);
    end
    chk("t3_burst", run, 6);
    chk("t3_count", got.size(), 6);
    if (got.size() == 6)
      for (int i = 0; i < 6; i++) chk("t3_order", got[i], w[i]);

    // Simultaneous capture and pop keeps rd_en high until the FIFO drains
    got.delete();
    for (int i = 0; i < 8; i++) begin
      w[i] = DW'($urandom);
      fq.push_back(w[i]);
    end
    bad = 0;
    for (int c = 0; c < 14; c++) begin
      step(1, 1, 0);
      if (!fifo_empty && !last_rd) bad++;
    end
    chk("t4_rd_gaps", bad, 0);
    chk("t4_count", got.size(), 8);
    if (got.size() == 8)
      for (int i = 0; i < 8; i++) chk("t4_order", got[i], w[i]);

    // Flush with one word buffered and one in flight
    got.delete();
    for (int i = 0; i < 4; i++) begin
      w[i] = DW'($urandom);
      fq.push_back(w[i]);
    end
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 1, 0);
    chk("t5_valid_after_flush", last_valid, 0);
    for (int c = 0; c < 8; c++) step(1, 1, 0);
    chk("t5_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t5_resume0", got[0], w[2]);
      chk("t5_resume1", got[1], w[3]);
    end

    // Reset mid-stream, then counter wrap
    got.delete();
    for (int i = 0; i < 4; i++) fq.push_back(DW'($urandom));
    repeat (3) step(1, 1, 0);
    repeat (2) step(0, 1, 0);
    chk("t6_valid_in_rst", last_valid, 0);
    chk("t6_cnt_in_rst", xfer_cnt, 0);
    fq.delete();
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      step(1, 1, 0);
      stray += int'(last_valid);
    end
    chk("t6_stray_valid", stray, 0);
    chk("t6_cnt_cleared", xfer_cnt, 0);
    got.delete();
    for (int i = 0; i < 17; i++) fq.push_back(DW'($urandom));
    for (int c = 0; c < 25; c++) step(1, 1, 0);
    chk("t6_wrap_cnt", xfer_cnt, 1);
    chk("t6_wrap_pops", got.size(), 17);

    // Randomised traffic with occasional flush and reset
    for (int c = 0; c < 400; c++) begin
      bit r, f, rdy;
      r   = ($urandom_range(0, 49) != 0);
      f   = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && fq.size() < 8) fq.push_back(DW'($urandom));
      step(r, rdy, f);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
